// File: rtl/watch_countdown_timer_pkg.sv
// Shared definitions for the watch countdown timer: FSM encodings, BCD digit constants,
// the BCD time record and a per-digit clamp helper.
package watch_countdown_timer_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StPause   = 2'd2;
  localparam logic [1:0] StExpired = 2'd3;

  localparam logic [3:0] BcdZero    = 4'd0;
  localparam logic [3:0] BcdOne     = 4'd1;
  localparam logic [3:0] BcdFiveMax = 4'd5;
  localparam logic [3:0] BcdNine    = 4'd9;

  typedef struct packed {
    logic [3:0] hh_t;
    logic [3:0] hh_u;
    logic [3:0] mm_t;
    logic [3:0] mm_u;
    logic [3:0] ss_t;
    logic [3:0] ss_u;
  } bcd_time_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: loads a clamped init value, wraps 0 -> MAX on decrement and
// reports a combinational borrow to the next more significant digit.
module bcd_down_digit
  import watch_countdown_timer_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] init,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow
);

  localparam logic [3:0] MaxDigit = 4'(MAX);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = clamp_digit(init, MaxDigit);
    end else if (dec) begin
      digit_d = (digit_q == BcdZero) ? MaxDigit : digit_q - BcdOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= BcdZero;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign borrow = dec & (digit_q == BcdZero);

endmodule

// File: rtl/watch_countdown_timer.sv
// HH:MM:SS BCD countdown timer with IDLE/RUN/PAUSE/EXPIRED control and a one-cycle done pulse.
// Optional TIMER_AUTORELOAD_EN: a tick in EXPIRED reloads the last set value and resumes running.
module watch_countdown_timer
  import watch_countdown_timer_pkg::*;
#(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       set,
  input  logic [3:0] init_hh_t,
  input  logic [3:0] init_hh_u,
  input  logic [3:0] init_mm_t,
  input  logic [3:0] init_mm_u,
  input  logic [3:0] init_ss_t,
  input  logic [3:0] init_ss_u,
  output logic [3:0] hh_t,
  output logic [3:0] hh_u,
  output logic [3:0] mm_t,
  output logic [3:0] mm_u,
  output logic [3:0] ss_t,
  output logic [3:0] ss_u,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic       done
);

  localparam logic [6:0] HourMax  = 7'(HOUR_MAX);
  localparam logic [3:0] HourMaxT = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HourMaxU = 4'(HOUR_MAX % 10);

  logic [1:0] state_q, state_d;
  logic       done_q, done_d;
  logic       count_dec;
  logic       reload;
  logic       snap_valid;
  logic       load;
  logic       count_zero;
  logic       count_one;

  logic [3:0] init_hh_t9, init_hh_u9;
  logic [6:0] init_hours;
  bcd_time_t  init_clamped;
  bcd_time_t  load_val;
  bcd_time_t  count;

  logic ss_u_borrow, ss_t_borrow, mm_u_borrow, mm_t_borrow, hh_u_borrow;
  logic unused_hh_t_borrow;

  // Hours clamp on the two-digit value, after each digit has been forced into BCD range.
  always_comb begin
    init_hh_t9 = clamp_digit(init_hh_t, BcdNine);
    init_hh_u9 = clamp_digit(init_hh_u, BcdNine);
    init_hours = 7'(init_hh_t9) * 7'd10 + 7'(init_hh_u9);
    if (init_hours > HourMax) begin
      init_clamped.hh_t = HourMaxT;
      init_clamped.hh_u = HourMaxU;
    end else begin
      init_clamped.hh_t = init_hh_t9;
      init_clamped.hh_u = init_hh_u9;
    end
    init_clamped.mm_t = clamp_digit(init_mm_t, BcdFiveMax);
    init_clamped.mm_u = clamp_digit(init_mm_u, BcdNine);
    init_clamped.ss_t = clamp_digit(init_ss_t, BcdFiveMax);
    init_clamped.ss_u = clamp_digit(init_ss_u, BcdNine);
  end

`ifdef TIMER_AUTORELOAD_EN
  bcd_time_t snap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
    end else if (set) begin
      snap_q <= init_clamped;
    end
  end

  assign snap_valid = (snap_q != '0);
  assign load_val   = reload ? snap_q : init_clamped;
`else
  assign snap_valid = 1'b0;
  assign load_val   = init_clamped;
`endif

  assign count      = '{hh_t: hh_t, hh_u: hh_u, mm_t: mm_t, mm_u: mm_u, ss_t: ss_t, ss_u: ss_u};
  assign count_zero = (count == '0);
  assign count_one  = (count == 24'h00_00_01);
  assign load       = set | reload;

  // Ticks are honoured only when no higher-priority control acts on the same edge.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    count_dec = 1'b0;
    reload    = 1'b0;
    if (set) begin
      state_d = StIdle;
    end else if (stop) begin
      if (state_q == StRun) begin
        state_d = StPause;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (start_resume && !count_zero) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!start_resume) begin
            state_d = StPause;
          end else if (tick && !count_zero) begin
            count_dec = 1'b1;
            if (count_one) begin
              state_d = StExpired;
              done_d  = 1'b1;
            end
          end
        end
        StPause: begin
          if (start_resume) begin
            state_d = StRun;
          end
        end
        StExpired: begin
          if (tick && snap_valid) begin
            reload  = 1'b1;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  bcd_down_digit #(.MAX(9)) u_ss_u (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .init   (load_val.ss_u),
    .dec    (count_dec),
    .digit  (ss_u),
    .borrow (ss_u_borrow)
  );

  bcd_down_digit #(.MAX(5)) u_ss_t (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .init   (load_val.ss_t),
    .dec    (ss_u_borrow),
    .digit  (ss_t),
    .borrow (ss_t_borrow)
  );

  bcd_down_digit #(.MAX(9)) u_mm_u (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .init   (load_val.mm_u),
    .dec    (ss_t_borrow),
    .digit  (mm_u),
    .borrow (mm_u_borrow)
  );

  bcd_down_digit #(.MAX(5)) u_mm_t (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .init   (load_val.mm_t),
    .dec    (mm_u_borrow),
    .digit  (mm_t),
    .borrow (mm_t_borrow)
  );

  bcd_down_digit #(.MAX(9)) u_hh_u (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .init   (load_val.hh_u),
    .dec    (mm_t_borrow),
    .digit  (hh_u),
    .borrow (hh_u_borrow)
  );

  // The count never decrements past 00:00:00, so the top hours digit never borrows.
  bcd_down_digit #(.MAX(HOUR_MAX / 10)) u_hh_t (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .init   (load_val.hh_t),
    .dec    (hh_u_borrow),
    .digit  (hh_t),
    .borrow (unused_hh_t_borrow)
  );

  assign running = (state_q == StRun);
  assign paused  = (state_q == StPause);
  assign expired = (state_q == StExpired);
  assign done    = done_q;

endmodule

// File: tb/tb_watch_countdown_timer.sv
// Bench for watch_countdown_timer: directed scenarios plus randomized control traffic, all
// compared against a seconds-based reference model of the timer.
module tb_watch_countdown_timer;

  localparam int MIdle = 0;
  localparam int MRun = 1;
  localparam int MPause = 2;
  localparam int MExp = 3;

  logic        clk;
  logic        reset, tick, start_resume, stop, set;
  logic [23:0] init_v;
  logic [3:0]  hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
  logic        running, paused, expired, done;
  logic [27:0] dut_vec;
  logic [23:0] digits;

  int n_checks = 0;
  int n_pass = 0;

  int m_secs = 0;
  int m_snap = 0;
  int m_st = MIdle;
  bit m_done = 1'b0;

  watch_countdown_timer #(.HOUR_MAX(23)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start_resume (start_resume),
    .stop         (stop),
    .set          (set),
    .init_hh_t    (init_v[23:20]),
    .init_hh_u    (init_v[19:16]),
    .init_mm_t    (init_v[15:12]),
    .init_mm_u    (init_v[11:8]),
    .init_ss_t    (init_v[7:4]),
    .init_ss_u    (init_v[3:0]),
    .hh_t         (hh_t),
    .hh_u         (hh_u),
    .mm_t         (mm_t),
    .mm_u         (mm_u),
    .ss_t         (ss_t),
    .ss_u         (ss_u),
    .running      (running),
    .paused       (paused),
    .expired      (expired),
    .done         (done)
  );

  assign dut_vec = {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, running, paused, expired, done};
  assign digits  = dut_vec[27:4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Load value in seconds after range limiting each field.
  function automatic int clamp_secs(input logic [23:0] v);
    int h, m, s;
    h = min_int(int'(v[23:20]), 9) * 10 + min_int(int'(v[19:16]), 9);
    if (h > 23) h = 23;
    m = min_int(int'(v[15:12]), 5) * 10 + min_int(int'(v[11:8]), 9);
    s = min_int(int'(v[7:4]), 5) * 10 + min_int(int'(v[3:0]), 9);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [27:0] model_vec();
    int h, m, s;
    h = m_secs / 3600;
    m = (m_secs / 60) % 60;
    s = m_secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            (m_st == MRun), (m_st == MPause), (m_st == MExp), m_done};
  endfunction

  task automatic model_edge();
    m_done = 1'b0;
    if (reset) begin
      m_secs = 0;
      m_snap = 0;
      m_st   = MIdle;
    end else if (set) begin
      m_secs = clamp_secs(init_v);
      m_snap = m_secs;
      m_st   = MIdle;
    end else if (stop) begin
      if (m_st == MRun) m_st = MPause;
    end else begin
      case (m_st)
        MIdle:  if (start_resume && m_secs != 0) m_st = MRun;
        MRun: begin
          if (!start_resume) begin
            m_st = MPause;
          end else if (tick) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
              m_st   = MExp;
              m_done = 1'b1;
            end
          end
        end
        MPause: if (start_resume) m_st = MRun;
        default: begin
`ifdef TIMER_AUTORELOAD_EN
          if (tick && m_snap != 0) begin
            m_secs = m_snap;
            m_st   = MRun;
          end
`endif
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("cyc", 32'(dut_vec), 32'(model_vec()));
  endtask

  task automatic do_set(input logic [23:0] v);
    init_v = v;
    set = 1'b1;
    cycle();
    set = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start_resume = 1'b0; stop = 1'b0; set = 1'b0; init_v = '0;
    #1;
    cycle();
    cycle();
    reset = 1'b0;
    check("reset_state", 32'(dut_vec), 32'd0);

    do_set(24'h00_01_00);
    start_resume = 1'b1;
    cycle();
    check("t1_running", 32'(running), 32'd1);
    tick_n(1);
    check("t1_digits", 32'(digits), 32'h00_00_59);

    do_set(24'h01_00_00);
    cycle();
    tick_n(1);
    check("t2_hour_borrow", 32'(digits), 32'h00_59_59);
    do_set(24'h10_00_00);
    cycle();
    tick_n(1);
    check("t2_bcd_hours", 32'(digits), 32'h09_59_59);

    do_set(24'h00_00_02);
    cycle();
    tick_n(2);
    check("t3_zero", 32'(digits), 32'd0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_expired", 32'(expired), 32'd1);
    cycle();
    check("t3_done_clear", 32'(done), 32'd0);
    check("t3_expired_hold", 32'(expired), 32'd1);
`ifndef TIMER_AUTORELOAD_EN
    tick_n(5);
    check("t3_stay_zero", 32'(digits), 32'd0);
    check("t3_stay_expired", 32'(expired), 32'd1);
`endif

    do_set(24'h00_00_10);
    cycle();
    tick_n(3);
    check("t4_count", 32'(digits), 32'h00_00_07);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    start_resume = 1'b0;
    check("t4_paused", 32'(paused), 32'd1);
    tick_n(4);
    check("t4_hold", 32'(digits), 32'h00_00_07);
    start_resume = 1'b1;
    cycle();
    tick_n(1);
    check("t4_resume", 32'(digits), 32'h00_00_06);

    do_set(24'h25_7A_99);
    check("t5_clamp", 32'(digits), 32'h23_59_59);
    do_set(24'h00_00_00);
    cycle();
    check("t5_zero_start", 32'(dut_vec), 32'd0);

    do_set(24'h00_01_00);
    cycle();
    tick_n(1);
    reset = 1'b1;
    tick = 1'b1;
    cycle();
    reset = 1'b0;
    tick = 1'b0;
    check("t6_reset_run", 32'(dut_vec), 32'd0);

`ifdef TIMER_AUTORELOAD_EN
    do_set(24'h00_00_01);
    cycle();
    tick_n(1);
    check("t6_ar_expired", 32'(expired), 32'd1);
    tick_n(1);
    check("t6_ar_reload", 32'(digits), 32'h00_00_01);
    check("t6_ar_running", 32'(running), 32'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      set          = ($urandom_range(0, 39) == 0);
      stop         = ($urandom_range(0, 19) == 0);
      start_resume = ($urandom_range(0, 9) != 0);
      tick         = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1)
        init_v = {16'h0000, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      else
        init_v = 24'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
